axis_seq_checker: RTL and testbench

- Synthesizable AXI4-Stream sink that replaces the simulation-only slave VIP plus scoreboard when checking counter-pattern packet traffic.
- Generates TREADY under a programmable always-on or oscillating policy.
- Checks each accepted beat against an expected per-packet sequence (counter byte lane, zero filler bytes, TLAST position).
- Exposes saturating beat, packet and error counters plus a sticky error code for status readout.

---
 rtl/axis_seq_checker_if.sv | 12 +
 rtl/axis_seq_checker.sv | 151 +++++++++++++++
 tb/tb_axis_seq_checker.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_seq_checker_if.sv
// AXI4-Stream handshake bundle between a traffic source and the sequence checker.
interface axis_seq_checker_if #(
   parameter int unsigned DATA_BYTES = 8
) ();
   logic [8*DATA_BYTES-1:0] tdata;
   logic                    tvalid;
   logic                    tlast;
   logic                    tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_seq_checker.sv
// AXI4-Stream sink that paces TREADY and checks counter-pattern packets,
// keeping saturating beat/packet/error counters and a sticky error code.
module axis_seq_checker #(
   parameter int unsigned DATA_BYTES  = 8,
   parameter int unsigned CNT_LANE    = 7,
   parameter int unsigned PKT_LEN     = 8,
   parameter int unsigned READY_MODE  = 1,
   parameter int unsigned READY_LOW   = 2,
   parameter int unsigned READY_HIGH  = 6,
   parameter int unsigned ZERO_CHECK  = 1,
   parameter int unsigned STOP_ON_ERR = 0,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic             enable,
   input  logic             clear,
   axis_seq_checker_if.slave s_axis,
   output logic [CNT_W-1:0] beat_count,
   output logic [CNT_W-1:0] pkt_count,
   output logic [CNT_W-1:0] err_count,
   output logic [3:0]       err_code,
   output logic             halted
);

   localparam int unsigned DW     = 8 * DATA_BYTES;
   localparam int unsigned PH_MAX = (READY_LOW > READY_HIGH) ? READY_LOW : READY_HIGH;
   localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam logic [DW-1:0] LANE_MASK = DW'(255) << (8 * CNT_LANE);
   localparam logic [7:0]    IDX_LAST  = 8'(PKT_LEN - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

   state_t          state;
   logic            tready_q;
   logic            phase_high;
   logic [PH_W-1:0] ph_cnt;
   logic [7:0]      idx;

   logic [DW-1:0] data_c;
   logic [7:0]    lane_c;
   logic          accept_c;
   logic          is_last_c;
   logic [3:0]    err_bits_c;
   logic          beat_err_c;
   logic          pkt_end_c;

   assign s_axis.tready = tready_q;

   // Per-beat checks against the expected sequence position.
   always_comb begin
      data_c        = s_axis.tdata;
      lane_c        = data_c[8*CNT_LANE +: 8];
      accept_c      = s_axis.tvalid & tready_q;
      is_last_c     = (idx == IDX_LAST);
      err_bits_c[0] = (lane_c != idx);
      err_bits_c[1] = (ZERO_CHECK != 0) && (|(data_c & ~LANE_MASK));
      err_bits_c[2] = s_axis.tlast & ~is_last_c;
      err_bits_c[3] = ~s_axis.tlast & is_last_c;
      beat_err_c    = |err_bits_c;
      pkt_end_c     = s_axis.tlast | is_last_c;
   end

   // Control FSM, TREADY pacing and status counters.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state      <= ST_IDLE;
         tready_q   <= 1'b0;
         phase_high <= 1'b0;
         ph_cnt     <= '0;
         idx        <= '0;
         beat_count <= '0;
         pkt_count  <= '0;
         err_count  <= '0;
         err_code   <= '0;
         halted     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               tready_q   <= 1'b0;
               phase_high <= 1'b0;
               ph_cnt     <= '0;
               if (enable) state <= ST_RUN;
            end
            ST_RUN: begin
               if (accept_c && beat_err_c && (STOP_ON_ERR != 0) && !clear) begin
                  state      <= ST_HALT;
                  halted     <= 1'b1;
                  tready_q   <= 1'b0;
                  phase_high <= 1'b0;
                  ph_cnt     <= '0;
               end else if (!enable) begin
                  state      <= ST_IDLE;
                  tready_q   <= 1'b0;
                  phase_high <= 1'b0;
                  ph_cnt     <= '0;
               end else if (READY_MODE == 0) begin
                  tready_q <= 1'b1;
               end else if (!phase_high) begin
                  if (ph_cnt == PH_W'(READY_LOW - 1)) begin
                     phase_high <= 1'b1;
                     ph_cnt     <= '0;
                     tready_q   <= 1'b1;
                  end else begin
                     ph_cnt   <= ph_cnt + PH_W'(1);
                     tready_q <= 1'b0;
                  end
               end else begin
                  if (ph_cnt == PH_W'(READY_HIGH - 1)) begin
                     phase_high <= 1'b0;
                     ph_cnt     <= '0;
                     tready_q   <= 1'b0;
                  end else begin
                     ph_cnt   <= ph_cnt + PH_W'(1);
                     tready_q <= 1'b1;
                  end
               end
            end
            ST_HALT: begin
               tready_q <= 1'b0;
               if (clear) state <= ST_IDLE;
            end
            default: begin
               state    <= ST_IDLE;
               tready_q <= 1'b0;
            end
         endcase

         // clear overrides any beat accepted in the same cycle
         if (clear) begin
            idx        <= '0;
            beat_count <= '0;
            pkt_count  <= '0;
            err_count  <= '0;
            err_code   <= '0;
            halted     <= 1'b0;
         end else if (accept_c) begin
            if (beat_count != '1) beat_count <= beat_count + CNT_W'(1);
            if (beat_err_c && (err_count != '1)) err_count <= err_count + CNT_W'(1);
            err_code <= err_code | err_bits_c;
            if (pkt_end_c) begin
               idx <= '0;
               if (pkt_count != '1) pkt_count <= pkt_count + CNT_W'(1);
            end else begin
               idx <= idx + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_seq_checker.sv
// Testbench for axis_seq_checker: scoreboarded main instance plus halt and
// saturation variants.
module tb_axis_seq_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0;
   logic en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;

   logic [15:0] bc0, pc0, ec0, bc1, pc1, ec1;
   logic [3:0]  bc2, pc2, ec2;
   logic [3:0]  code0, code1, code2;
   logic        h0, h1, h2;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [15:0] b;
      logic [15:0] p;
      logic [15:0] e;
      logic [3:0]  c;
   } exp_t;

   exp_t sbq[$];
   int          m_idx;
   logic [15:0] m_b, m_p, m_e;
   logic [3:0]  m_c;

   always #5 clk = ~clk;

   axis_seq_checker_if #(.DATA_BYTES(8)) ax0 ();
   axis_seq_checker_if #(.DATA_BYTES(8)) ax1 ();
   axis_seq_checker_if #(.DATA_BYTES(8)) ax2 ();

   axis_seq_checker #(.DATA_BYTES(8), .CNT_LANE(7), .PKT_LEN(8), .READY_MODE(1),
      .READY_LOW(2), .READY_HIGH(6), .ZERO_CHECK(1), .STOP_ON_ERR(0), .CNT_W(16)) dut0 (
      .aclk(clk), .areset(rst), .enable(en0), .clear(clr), .s_axis(ax0),
      .beat_count(bc0), .pkt_count(pc0), .err_count(ec0), .err_code(code0), .halted(h0));

   axis_seq_checker #(.DATA_BYTES(8), .CNT_LANE(7), .PKT_LEN(8), .READY_MODE(1),
      .READY_LOW(2), .READY_HIGH(6), .ZERO_CHECK(1), .STOP_ON_ERR(1), .CNT_W(16)) dut1 (
      .aclk(clk), .areset(rst), .enable(en1), .clear(clr), .s_axis(ax1),
      .beat_count(bc1), .pkt_count(pc1), .err_count(ec1), .err_code(code1), .halted(h1));

   axis_seq_checker #(.DATA_BYTES(8), .CNT_LANE(7), .PKT_LEN(8), .READY_MODE(0),
      .READY_LOW(2), .READY_HIGH(6), .ZERO_CHECK(1), .STOP_ON_ERR(0), .CNT_W(4)) dut2 (
      .aclk(clk), .areset(rst), .enable(en2), .clear(clr), .s_axis(ax2),
      .beat_count(bc2), .pkt_count(pc2), .err_count(ec2), .err_code(code2), .halted(h2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic rdy(input int sel);
      case (sel)
         0:       return ax0.tready;
         1:       return ax1.tready;
         default: return ax2.tready;
      endcase
   endfunction

   task automatic stop_valid();
      ax0.tvalid = 1'b0;
      ax1.tvalid = 1'b0;
      ax2.tvalid = 1'b0;
   endtask

   task automatic model_clear();
      m_idx = 0; m_b = '0; m_p = '0; m_e = '0; m_c = '0;
      sbq.delete();
   endtask

   task automatic do_clear();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      model_clear();
   endtask

   // Predict dut0 status after this beat, then offer it until it is taken.
   task automatic send_beat(input int sel, input logic [7:0] cnt, input logic [7:0] fill,
                            input logic last);
      logic [63:0] d;
      logic [3:0]  bits;
      logic        at_end;
      int          guard;
      d = {cnt, {7{fill}}};
      if (sel == 0) begin
         at_end  = (m_idx == 7);
         bits[0] = (cnt != 8'(m_idx));
         bits[1] = (fill != 8'h00);
         bits[2] = last && !at_end;
         bits[3] = !last && at_end;
         if (m_b != 16'hFFFF) m_b = m_b + 16'd1;
         if (bits != 4'b0) m_e = m_e + 16'd1;
         m_c = m_c | bits;
         if (last || at_end) begin
            m_p   = m_p + 16'd1;
            m_idx = 0;
         end else begin
            m_idx = m_idx + 1;
         end
         sbq.push_back({m_b, m_p, m_e, m_c});
      end
      case (sel)
         0:       begin ax0.tdata = d; ax0.tlast = last; ax0.tvalid = 1'b1; end
         1:       begin ax1.tdata = d; ax1.tlast = last; ax1.tvalid = 1'b1; end
         default: begin ax2.tdata = d; ax2.tlast = last; ax2.tvalid = 1'b1; end
      endcase
      guard = 0;
      while (!rdy(sel) && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) begin
         n_checks++; n_errors++;
         $display("FAIL handshake_timeout: dut%0d tready stayed %b, required 1", sel, rdy(sel));
      end
      tick();
   endtask

   // Scoreboard: compare dut0 status one cycle after each accepted beat.
   initial begin : monitor
      logic pend;
      exp_t e;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (pend) begin
            n_checks++;
            if (sbq.size() == 0) begin
               n_errors++;
               $display("FAIL sb_empty: beat accepted with no expectation queued");
            end else begin
               e = sbq.pop_front();
               if ({bc0, pc0, ec0, code0} !== e) begin
                  n_errors++;
                  $display("FAIL scoreboard: got beats=%0d pkts=%0d errs=%0d code=%b, required beats=%0d pkts=%0d errs=%0d code=%b",
                           bc0, pc0, ec0, code0, e.b, e.p, e.e, e.c);
               end
            end
         end
         pend = ax0.tvalid && ax0.tready && !clr && !rst;
      end
   end

   task automatic test_reset();
      n_checks++;
      if ({ax0.tready, bc0, pc0, ec0, code0, h0} !== '0) begin
         n_errors++;
         $display("FAIL reset_dut0: tready=%b b=%0d p=%0d e=%0d code=%b halted=%b, required all 0",
                  ax0.tready, bc0, pc0, ec0, code0, h0);
      end
      n_checks++;
      if ({ax1.tready, bc1, code1, h1, ax2.tready, bc2, code2, h2} !== '0) begin
         n_errors++;
         $display("FAIL reset_variants: tready1=%b b1=%0d h1=%b tready2=%b b2=%0d h2=%b, required all 0",
                  ax1.tready, bc1, h1, ax2.tready, bc2, h2);
      end
   endtask

   task automatic test_ready_policy();
      logic exp_r;
      int   highs;
      highs = 0;
      en0 = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         exp_r = ((i % 8) >= 2);
         if (ax0.tready === 1'b1) highs++;
         n_checks++;
         if (ax0.tready !== exp_r) begin
            n_errors++;
            $display("FAIL ready_phase[%0d]: got %b, required %b", i, ax0.tready, exp_r);
         end
      end
      n_checks++;
      if (highs != 12) begin
         n_errors++;
         $display("FAIL ready_duty: got %0d high cycles in 16, required 12", highs);
      end
      tick();
   endtask

   task automatic test_good_stream();
      do_clear();
      for (int p = 0; p < 8; p++)
         for (int b = 0; b < 8; b++)
            send_beat(0, 8'(b), 8'h00, b == 7);
      stop_valid();
      tick();
      n_checks++;
      if ({bc0, pc0, ec0, code0} !== {16'd64, 16'd8, 16'd0, 4'd0}) begin
         n_errors++;
         $display("FAIL good_stream: got b=%0d p=%0d e=%0d code=%b, required 64 8 0 0000",
                  bc0, pc0, ec0, code0);
      end
   endtask

   task automatic test_bad_counter();
      do_clear();
      for (int b = 0; b < 8; b++)
         send_beat(0, (b == 3) ? 8'h05 : 8'(b), 8'h00, b == 7);
      stop_valid();
      tick();
      n_checks++;
      if ({bc0, pc0, ec0, code0} !== {16'd8, 16'd1, 16'd1, 4'b0001}) begin
         n_errors++;
         $display("FAIL bad_counter: got b=%0d p=%0d e=%0d code=%b, required 8 1 1 0001",
                  bc0, pc0, ec0, code0);
      end
   endtask

   task automatic test_early_last();
      do_clear();
      for (int b = 0; b < 5; b++) send_beat(0, 8'(b), 8'h00, b == 4);
      for (int b = 0; b < 8; b++) send_beat(0, 8'(b), 8'h00, b == 7);
      stop_valid();
      tick();
      n_checks++;
      if ({bc0, pc0, ec0, code0} !== {16'd13, 16'd2, 16'd1, 4'b0100}) begin
         n_errors++;
         $display("FAIL early_last: got b=%0d p=%0d e=%0d code=%b, required 13 2 1 0100",
                  bc0, pc0, ec0, code0);
      end
   endtask

   task automatic test_missing_last();
      do_clear();
      for (int b = 0; b < 16; b++) send_beat(0, 8'(b % 8), 8'h00, 1'b0);
      stop_valid();
      tick();
      n_checks++;
      if ({bc0, pc0, ec0, code0} !== {16'd16, 16'd2, 16'd2, 4'b1000}) begin
         n_errors++;
         $display("FAIL missing_last: got b=%0d p=%0d e=%0d code=%b, required 16 2 2 1000",
                  bc0, pc0, ec0, code0);
      end
   endtask

   task automatic test_enable_drop();
      do_clear();
      for (int b = 0; b < 3; b++) send_beat(0, 8'(b), 8'h00, 1'b0);
      stop_valid();
      en0 = 1'b0;
      repeat (4) tick();
      n_checks++;
      if (ax0.tready !== 1'b0) begin
         n_errors++;
         $display("FAIL disabled_ready: got %b, required 0", ax0.tready);
      end
      en0 = 1'b1;
      for (int b = 3; b < 8; b++) send_beat(0, 8'(b), 8'h00, b == 7);
      stop_valid();
      tick();
      n_checks++;
      if ({bc0, pc0, ec0, code0} !== {16'd8, 16'd1, 16'd0, 4'd0}) begin
         n_errors++;
         $display("FAIL enable_resume: got b=%0d p=%0d e=%0d code=%b, required 8 1 0 0000",
                  bc0, pc0, ec0, code0);
      end
   endtask

   task automatic test_clear_with_beat();
      int guard;
      do_clear();
      for (int b = 0; b < 3; b++) send_beat(0, 8'(b), 8'h00, 1'b0);
      stop_valid();
      guard = 0;
      while (!ax0.tready && guard < 50) begin
         tick();
         guard++;
      end
      n_checks++;
      if (guard >= 50) begin
         n_errors++;
         $display("FAIL clear_wait: tready stayed %b, required 1", ax0.tready);
      end
      ax0.tdata = {8'd3, 56'd0};
      ax0.tlast = 1'b0;
      ax0.tvalid = 1'b1;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      stop_valid();
      model_clear();
      n_checks++;
      if ({bc0, pc0, ec0, code0} !== '0) begin
         n_errors++;
         $display("FAIL clear_beat: got b=%0d p=%0d e=%0d code=%b, required all 0",
                  bc0, pc0, ec0, code0);
      end
      for (int b = 0; b < 8; b++) send_beat(0, 8'(b), 8'h00, b == 7);
      stop_valid();
      tick();
      n_checks++;
      if ({bc0, pc0, ec0, code0} !== {16'd8, 16'd1, 16'd0, 4'd0}) begin
         n_errors++;
         $display("FAIL clear_restart: got b=%0d p=%0d e=%0d code=%b, required 8 1 0 0000",
                  bc0, pc0, ec0, code0);
      end
   endtask

   task automatic test_halt();
      en1 = 1'b1;
      do_clear();
      send_beat(1, 8'h00, 8'hFF, 1'b0);
      stop_valid();
      n_checks++;
      if ({h1, ax1.tready, bc1, ec1, code1} !== {1'b1, 1'b0, 16'd1, 16'd1, 4'b0010}) begin
         n_errors++;
         $display("FAIL halt_entry: got halted=%b tready=%b b=%0d e=%0d code=%b, required 1 0 1 1 0010",
                  h1, ax1.tready, bc1, ec1, code1);
      end
      ax1.tdata = {8'd1, 56'd0};
      ax1.tlast = 1'b0;
      ax1.tvalid = 1'b1;
      repeat (10) tick();
      stop_valid();
      n_checks++;
      if ({h1, ax1.tready, bc1} !== {1'b1, 1'b0, 16'd1}) begin
         n_errors++;
         $display("FAIL halt_hold: got halted=%b tready=%b b=%0d, required 1 0 1", h1, ax1.tready, bc1);
      end
      do_clear();
      n_checks++;
      if ({h1, bc1, ec1, code1} !== '0) begin
         n_errors++;
         $display("FAIL halt_clear: got halted=%b b=%0d e=%0d code=%b, required all 0", h1, bc1, ec1, code1);
      end
      send_beat(1, 8'h00, 8'h00, 1'b0);
      stop_valid();
      n_checks++;
      if ({h1, bc1, ec1, code1} !== {1'b0, 16'd1, 16'd0, 4'd0}) begin
         n_errors++;
         $display("FAIL halt_resume: got halted=%b b=%0d e=%0d code=%b, required 0 1 0 0000",
                  h1, bc1, ec1, code1);
      end
      en1 = 1'b0;
   endtask

   task automatic test_saturation_reset();
      en2 = 1'b1;
      tick();
      do_clear();
      for (int b = 0; b < 20; b++) send_beat(2, 8'(b % 8), 8'h00, (b % 8) == 7);
      n_checks++;
      if ({bc2, pc2, ec2, code2} !== {4'd15, 4'd2, 4'd0, 4'd0}) begin
         n_errors++;
         $display("FAIL saturation: got b=%0d p=%0d e=%0d code=%b, required 15 2 0 0000",
                  bc2, pc2, ec2, code2);
      end
      n_checks++;
      if (ax2.tready !== 1'b1) begin
         n_errors++;
         $display("FAIL pre_reset_ready: got %b, required 1", ax2.tready);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({ax2.tready, bc2, pc2, ec2, code2, h2, ax0.tready, bc0} !== '0) begin
         n_errors++;
         $display("FAIL async_reset: got tready2=%b b2=%0d p2=%0d tready0=%b b0=%0d, required all 0",
                  ax2.tready, bc2, pc2, ax0.tready, bc0);
      end
      stop_valid();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      ax0.tdata = '0; ax0.tlast = 1'b0; ax0.tvalid = 1'b0;
      ax1.tdata = '0; ax1.tlast = 1'b0; ax1.tvalid = 1'b0;
      ax2.tdata = '0; ax2.tlast = 1'b0; ax2.tvalid = 1'b0;
      model_clear();
      repeat (3) tick();
      rst = 1'b0;
      tick();
      test_reset();
      test_ready_policy();
      test_good_stream();
      test_bad_counter();
      test_early_last();
      test_missing_last();
      test_enable_drop();
      test_clear_with_beat();
      test_halt();
      test_saturation_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
